// File: rtl/gpio_pad_bank.sv
// N-channel GPIO bank: direction/output registers, synchronised and debounced inputs,
// and edge-detect with sticky interrupt status, programmed over a register strobe bus.
module gpio_pad_bank #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      reg_addr,
    input  logic [N_CH-1:0] reg_wdata,
    input  logic            reg_we,
    input  logic            reg_re,
    output logic [N_CH-1:0] reg_rdata,
    output logic            reg_rvalid,
    input  logic [N_CH-1:0] pad_p2c,
    output logic [N_CH-1:0] pad_c2p,
    output logic [N_CH-1:0] pad_c2p_en,
    output logic            irq
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    localparam logic [2:0] A_DIR      = 3'd0;
    localparam logic [2:0] A_OUT      = 3'd1;
    localparam logic [2:0] A_IN       = 3'd2;
    localparam logic [2:0] A_IRQ_EN   = 3'd3;
    localparam logic [2:0] A_IRQ_STAT = 3'd4;
    localparam logic [2:0] A_EDGE_SEL = 3'd5;
    localparam logic [2:0] A_OUT_SET  = 3'd6;
    localparam logic [2:0] A_OUT_CLR  = 3'd7;

    logic [N_CH-1:0] dir_q, dir_d;
    logic [N_CH-1:0] out_q, out_d;
    logic [N_CH-1:0] irq_en_q, irq_en_d;
    logic [N_CH-1:0] irq_stat_q, irq_stat_d;
    logic [N_CH-1:0] edge_sel_q, edge_sel_d;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0] filt_q, filt_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0] rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            irq_q, irq_d;

    logic [N_CH-1:0] w1c;
    logic [N_CH-1:0] stat_set;
    logic [N_CH-1:0] sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Register writes; status clears are merged with edge sets below so a set wins.
    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        if (reg_we) begin
            case (reg_addr)
                A_DIR:      dir_d      = reg_wdata;
                A_OUT:      out_d      = reg_wdata;
                A_IRQ_EN:   irq_en_d   = reg_wdata;
                A_IRQ_STAT: w1c        = reg_wdata;
                A_EDGE_SEL: edge_sel_d = reg_wdata;
                A_OUT_SET:  out_d      = out_q | reg_wdata;
                A_OUT_CLR:  out_d      = out_q & ~reg_wdata;
                default:    ;
            endcase
        end
        irq_stat_d = (irq_stat_q & ~w1c) | stat_set;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    // Synchroniser, debounce filter and edge detect, independent of direction.
    always_comb begin
        sync_d[0] = pad_p2c;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        stat_set = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (DEB_CYCLES == 0) begin
                filt_d[i] = sync_s[i];
            end else if (sync_s[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEB_CYCLES)) begin
                // new level accepted on the edge after DEB_CYCLES counted mismatches
                filt_d[i] = sync_s[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            stat_set[i] = (filt_d[i] != filt_q[i]) && (filt_d[i] == edge_sel_q[i]);
        end
    end

    // Read mux samples pre-write state.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = reg_re;
        if (reg_re) begin
            case (reg_addr)
                A_DIR:      rdata_d = dir_q;
                A_OUT:      rdata_d = out_q;
                A_IN:       rdata_d = filt_q;
                A_IRQ_EN:   rdata_d = irq_en_q;
                A_IRQ_STAT: rdata_d = irq_stat_q;
                A_EDGE_SEL: rdata_d = edge_sel_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= '0;
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            edge_sel_q <= '0;
            sync_q     <= '0;
            filt_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            edge_sel_q <= edge_sel_d;
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign pad_c2p    = out_q;
    assign pad_c2p_en = dir_q;
    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed bench for gpio_pad_bank: register access, debounce latency, glitch rejection,
// interrupt set/clear ordering and reset mid-debounce.
module tb_gpio_pad_bank;

    localparam int unsigned N_CH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      reg_addr;
    logic [N_CH-1:0] reg_wdata;
    logic            reg_we;
    logic            reg_re;
    logic [N_CH-1:0] reg_rdata;
    logic            reg_rvalid;
    logic [N_CH-1:0] pad_p2c;
    logic [N_CH-1:0] pad_c2p;
    logic [N_CH-1:0] pad_c2p_en;
    logic            irq;

    int n_checks = 0;
    int n_errors = 0;

    gpio_pad_bank #(.N_CH(N_CH), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .pad_p2c    (pad_p2c),
        .pad_c2p    (pad_c2p),
        .pad_c2p_en (pad_c2p_en),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [N_CH-1:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        tick(1);
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [N_CH-1:0] d);
        reg_addr = a;
        reg_re   = 1'b1;
        tick(1);
        reg_re   = 1'b0;
        check("rvalid", 32'(reg_rvalid), 32'd1);
        d = reg_rdata;
    endtask

    logic [N_CH-1:0] v;

    initial begin
        rst       = 1'b1;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        pad_p2c   = '0;
        tick(3);
        rst = 1'b0;

        // post-reset state
        check("rst_c2p_en", 32'(pad_c2p_en), 32'h00);
        check("rst_c2p", 32'(pad_c2p), 32'h00);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rvalid", 32'(reg_rvalid), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            check("rst_read", 32'(v), 32'h00);
        end
        tick(1);
        check("rvalid_pulse", 32'(reg_rvalid), 32'd0);

        // output registers
        wr(3'd0, 8'hF0);
        check("dir_pad", 32'(pad_c2p_en), 32'hF0);
        wr(3'd1, 8'hA5);
        check("out_pad", 32'(pad_c2p), 32'hA5);
        wr(3'd6, 8'h0A);
        check("out_set", 32'(pad_c2p), 32'hAF);
        wr(3'd7, 8'h81);
        check("out_clr", 32'(pad_c2p), 32'h2E);
        wr(3'd2, 8'hFF);
        rd(3'd2, v);
        check("in_ro", 32'(v), 32'h00);
        rd(3'd0, v);
        check("dir_rd", 32'(v), 32'hF0);
        rd(3'd1, v);
        check("out_rd", 32'(v), 32'h2E);
        rd(3'd6, v);
        check("set_rd0", 32'(v), 32'h00);

        // read and write of the same address in one cycle returns the old value
        reg_addr  = 3'd1;
        reg_wdata = 8'h11;
        reg_we    = 1'b1;
        reg_re    = 1'b1;
        tick(1);
        reg_we = 1'b0;
        reg_re = 1'b0;
        check("rw_old", 32'(reg_rdata), 32'h2E);
        check("rw_new", 32'(pad_c2p), 32'h11);

        // ch0 rising: IN[0] appears at t0+6, not at t0+5
        pad_p2c[0] = 1'b1;
        tick(6);
        rd(3'd2, v);
        check("in_lat_early", 32'(v), 32'h00);
        rd(3'd2, v);
        check("in_lat", 32'(v), 32'h01);

        // 3-cycle glitch on ch1 is filtered
        pad_p2c[1] = 1'b1;
        tick(3);
        pad_p2c[1] = 1'b0;
        tick(10);
        rd(3'd2, v);
        check("glitch_in", 32'(v), 32'h01);
        rd(3'd4, v);
        check("glitch_stat", 32'(v), 32'h00);

        // rising-edge interrupt on ch0; falling edge must not set
        wr(3'd5, 8'h01);
        wr(3'd3, 8'h01);
        pad_p2c[0] = 1'b0;
        tick(10);
        rd(3'd4, v);
        check("fall_nostat", 32'(v), 32'h00);
        check("fall_noirq", 32'(irq), 32'd0);
        pad_p2c[0] = 1'b1;
        tick(6);
        check("irq_t5", 32'(irq), 32'd0);
        tick(1);
        check("irq_t6", 32'(irq), 32'd0);
        tick(1);
        check("irq_t7", 32'(irq), 32'd1);
        rd(3'd4, v);
        check("stat_set", 32'(v), 32'h01);
        wr(3'd4, 8'h01);
        check("irq_w1c_1", 32'(irq), 32'd1);
        tick(1);
        check("irq_w1c_2", 32'(irq), 32'd0);
        rd(3'd4, v);
        check("stat_clr", 32'(v), 32'h00);

        // W1C coinciding with a qualifying edge: set wins
        pad_p2c[0] = 1'b0;
        tick(10);
        pad_p2c[0] = 1'b1;
        tick(6);
        wr(3'd4, 8'h01);
        rd(3'd4, v);
        check("set_wins", 32'(v), 32'h01);
        wr(3'd4, 8'h01);
        rd(3'd4, v);
        check("stat_clr2", 32'(v), 32'h00);

        // reset while ch2 is mid-debounce, with a read strobe in the reset cycle
        pad_p2c[2] = 1'b1;
        tick(4);
        rst    = 1'b1;
        reg_re = 1'b1;
        tick(1);
        rst    = 1'b0;
        reg_re = 1'b0;
        check("rst2_rvalid", 32'(reg_rvalid), 32'd0);
        check("rst2_c2p_en", 32'(pad_c2p_en), 32'h00);
        check("rst2_c2p", 32'(pad_c2p), 32'h00);
        check("rst2_irq", 32'(irq), 32'd0);
        tick(6);
        rd(3'd2, v);
        check("rst2_in_early", 32'(v), 32'h00);
        rd(3'd2, v);
        check("rst2_in", 32'(v), 32'h05);
        rd(3'd4, v);
        check("rst2_stat", 32'(v), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
